// File: rtl/uart_tx_fsm_pkg.sv
// rtl/uart_tx_fsm_pkg.sv - shared encodings and helpers for the UART transmit control FSM
package uart_tx_fsm_pkg;

  // Line mux selects, shared with the transmit datapath
  localparam logic [1:0] SEL_START = 2'b00;
  localparam logic [1:0] SEL_IDLE  = 2'b01;
  localparam logic [1:0] SEL_DATA  = 2'b10;
  localparam logic [1:0] SEL_PAR   = 2'b11;

  // FSM state encodings
  localparam int STATE_W = 3;
  localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] ST_START  = 3'd1;
  localparam logic [STATE_W-1:0] ST_DATA   = 3'd2;
  localparam logic [STATE_W-1:0] ST_PARITY = 3'd3;
  localparam logic [STATE_W-1:0] ST_STOP1  = 3'd4;
  localparam logic [STATE_W-1:0] ST_STOP2  = 3'd5;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE   = ST_IDLE,
    S_START  = ST_START,
    S_DATA   = ST_DATA,
    S_PARITY = ST_PARITY,
    S_STOP1  = ST_STOP1,
    S_STOP2  = ST_STOP2
  } state_t;

  // Watchdog counter must hold values up to DATA_WIDTH+WD_SLACK
  function automatic int wd_cnt_width(input int data_width, input int wd_slack);
    return $clog2(data_width + wd_slack + 1);
  endfunction

endpackage

// File: rtl/uart_tx_fsm_if.sv
// rtl/uart_tx_fsm_if.sv - handshake and datapath control bundle of the UART transmit FSM
interface uart_tx_fsm_if;
  logic       data_valid;
  logic       par_en;
  logic       stop2;
  logic       ser_done;
  logic       tx_ready;
  logic       ser_load;
  logic [1:0] mux_sel;
  logic       busy;
  logic       frame_done;
  logic       ser_err;

  // Producer / datapath side
  modport master (
    output data_valid, par_en, stop2, ser_done,
    input  tx_ready, ser_load, mux_sel, busy, frame_done, ser_err
  );

  // FSM side
  modport slave (
    input  data_valid, par_en, stop2, ser_done,
    output tx_ready, ser_load, mux_sel, busy, frame_done, ser_err
  );
endinterface

// File: rtl/uart_tx_fsm.sv
// rtl/uart_tx_fsm.sv - UART transmit sequencer: start/data/parity/stop phases with serializer watchdog
module uart_tx_fsm
  import uart_tx_fsm_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int WD_SLACK   = 2
) (
  input  logic         clk,
  input  logic         rst,
  uart_tx_fsm_if.slave bus
);

  localparam int CNT_W = wd_cnt_width(DATA_WIDTH, WD_SLACK);
  // Value held during the last DATA cycle the serializer is allowed
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(DATA_WIDTH + WD_SLACK - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wd_cnt;
  logic             par_q, stop2_q;
  logic             busy_q, err_q;
  logic             ready, accept, final_stop, wd_fire;
  logic [1:0]       sel;

  // Next-state, Moore line select and handshake decode
  always_comb begin
    state_nxt  = state;
    sel        = SEL_IDLE;
    ready      = 1'b0;
    final_stop = 1'b0;
    wd_fire    = 1'b0;
    accept     = 1'b0;
    case (state)
      S_IDLE: begin
        sel   = SEL_IDLE;
        ready = 1'b1;
      end
      S_START: begin
        sel       = SEL_START;
        state_nxt = S_DATA;
      end
      S_DATA: begin
        sel = SEL_DATA;
        if (bus.ser_done) begin
          state_nxt = par_q ? S_PARITY : S_STOP1;
        end else if (wd_cnt == WD_LAST) begin
          // Serializer never finished: truncate the frame rather than hang
          wd_fire   = 1'b1;
          state_nxt = S_STOP1;
        end
      end
      S_PARITY: begin
        sel       = SEL_PAR;
        state_nxt = S_STOP1;
      end
      S_STOP1: begin
        sel = SEL_IDLE;
        if (stop2_q) begin
          state_nxt = S_STOP2;
        end else begin
          final_stop = 1'b1;
        end
      end
      S_STOP2: begin
        sel        = SEL_IDLE;
        final_stop = 1'b1;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    // The final stop cycle can hand straight over to the next frame
    if (final_stop) begin
      ready = 1'b1;
    end
    accept = ready & bus.data_valid;
    if (accept) begin
      state_nxt = S_START;
    end else if (final_stop) begin
      state_nxt = S_IDLE;
    end
  end

  // State, frame configuration, watchdog counter and sticky error
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      busy_q  <= 1'b0;
      par_q   <= 1'b0;
      stop2_q <= 1'b0;
      wd_cnt  <= '0;
      err_q   <= 1'b0;
    end else begin
      state  <= state_nxt;
      busy_q <= (state_nxt != S_IDLE);
      if (accept) begin
        par_q   <= bus.par_en;
        stop2_q <= bus.stop2;
      end
      if (state == S_START) begin
        wd_cnt <= '0;
      end else if (state == S_DATA) begin
        wd_cnt <= wd_cnt + CNT_W'(1);
      end
      if (wd_fire) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.tx_ready   = ready;
  assign bus.ser_load   = accept;
  assign bus.mux_sel    = sel;
  assign bus.busy       = busy_q;
  assign bus.frame_done = final_stop;
  assign bus.ser_err    = err_q;

endmodule

// File: tb/tb_uart_tx_fsm.sv
// tb/tb_uart_tx_fsm.sv - self-checking bench for the UART transmit sequencer
module tb_uart_tx_fsm;

  localparam int DW    = 8;
  localparam int SLACK = 2;
  localparam int LIMIT = DW + SLACK;

  logic clk;
  logic rst;

  uart_tx_fsm_if bus ();

  uart_tx_fsm #(.DATA_WIDTH(DW), .WD_SLACK(SLACK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame descriptor: done_at is the DATA cycle index of ser_done, -1 = never
  typedef struct {
    bit pe;
    bit s2;
    int done_at;
    bit spur;
    bit b2b;
  } vec_t;

  // One bit-clock cycle: stimulus plus expected outputs
  typedef struct {
    logic       dv, pe, s2, sd;
    logic [1:0] mux;
    logic       busy, rdy, load, fd, err;
  } cyc_t;

  cyc_t tl[$];
  bit   err_sticky;
  int   n_cmp;
  int   n_bad;
  int   cyc_no;

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic cyc_t mk(logic dv, logic pe, logic s2, logic sd, logic [1:0] mux,
                              logic busy, logic rdy, logic load, logic fd);
    cyc_t c;
    c.dv = dv; c.pe = pe; c.s2 = s2; c.sd = sd;
    c.mux = mux; c.busy = busy; c.rdy = rdy; c.load = load; c.fd = fd;
    c.err = err_sticky;
    return c;
  endfunction

  task automatic add_idle(input int n);
    for (int i = 0; i < n; i++) tl.push_back(mk(1'b0, rb(), rb(), rb(), 2'b01, 1'b0, 1'b1, 1'b0, 1'b0));
  endtask

  // Expected timeline of one frame, built from the frame-length rule
  task automatic add_frame(input vec_t v);
    int n;
    int idx;
    if (v.b2b && tl.size() > 0) begin
      idx = tl.size() - 1;
      tl[idx].dv = 1'b1; tl[idx].pe = v.pe; tl[idx].s2 = v.s2; tl[idx].load = 1'b1;
    end else begin
      tl.push_back(mk(1'b1, v.pe, v.s2, rb(), 2'b01, 1'b0, 1'b1, 1'b1, 1'b0));
    end
    tl.push_back(mk(rb(), rb(), rb(), v.spur, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0));
    n = (v.done_at < 0) ? LIMIT : v.done_at + 1;
    for (int k = 0; k < n; k++)
      tl.push_back(mk(rb(), rb(), rb(), logic'(k == v.done_at), 2'b10, 1'b1, 1'b0, 1'b0, 1'b0));
    if (v.done_at < 0) err_sticky = 1'b1;
    if (v.pe && v.done_at >= 0)
      tl.push_back(mk(rb(), rb(), rb(), rb(), 2'b11, 1'b1, 1'b0, 1'b0, 1'b0));
    if (v.s2) begin
      tl.push_back(mk(rb(), rb(), rb(), rb(), 2'b01, 1'b1, 1'b0, 1'b0, 1'b0));
      tl.push_back(mk(1'b0, rb(), rb(), rb(), 2'b01, 1'b1, 1'b1, 1'b0, 1'b1));
    end else begin
      tl.push_back(mk(1'b0, rb(), rb(), rb(), 2'b01, 1'b1, 1'b1, 1'b0, 1'b1));
    end
  endtask

  task automatic check_now(input string name, input cyc_t e);
    logic [6:0] got, exp;
    got = {bus.mux_sel, bus.busy, bus.tx_ready, bus.ser_load, bus.frame_done, bus.ser_err};
    exp = {e.mux, e.busy, e.rdy, e.load, e.fd, e.err};
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got {mux,busy,rdy,load,fd,err}=%b required %b", name, cyc_no, got, exp);
    end
  endtask

  // Drive each scheduled cycle and compare the DUT against its expected entry
  task automatic run_n(input int n);
    cyc_t e;
    for (int i = 0; i < n && tl.size() > 0; i++) begin
      e = tl.pop_front();
      @(posedge clk);
      #1;
      bus.data_valid = e.dv;
      bus.par_en     = e.pe;
      bus.stop2      = e.s2;
      bus.ser_done   = e.sd;
      #1;
      check_now("seq", e);
      cyc_no++;
    end
  endtask

  vec_t vecs[9];
  cyc_t idle_exp;

  initial begin
    n_cmp = 0; n_bad = 0; cyc_no = 0; err_sticky = 1'b0;
    bus.data_valid = 1'b0; bus.par_en = 1'b0; bus.stop2 = 1'b0; bus.ser_done = 1'b0;

    vecs[0] = '{pe: 1'b1, s2: 1'b0, done_at: 7,  spur: 1'b0, b2b: 1'b0};
    vecs[1] = '{pe: 1'b0, s2: 1'b1, done_at: 7,  spur: 1'b0, b2b: 1'b0};
    vecs[2] = '{pe: 1'b0, s2: 1'b1, done_at: 7,  spur: 1'b0, b2b: 1'b1};
    vecs[3] = '{pe: 1'b1, s2: 1'b1, done_at: 7,  spur: 1'b1, b2b: 1'b1};
    vecs[4] = '{pe: 1'b0, s2: 1'b0, done_at: 9,  spur: 1'b0, b2b: 1'b0};
    vecs[5] = '{pe: 1'b1, s2: 1'b0, done_at: 3,  spur: 1'b1, b2b: 1'b0};
    vecs[6] = '{pe: 1'b1, s2: 1'b0, done_at: -1, spur: 1'b0, b2b: 1'b0};
    vecs[7] = '{pe: 1'b1, s2: 1'b0, done_at: 7,  spur: 1'b0, b2b: 1'b0};
    vecs[8] = '{pe: 1'b0, s2: 1'b1, done_at: 7,  spur: 1'b1, b2b: 1'b1};

    // Reset held for three cycles
    rst = 1'b0;
    idle_exp = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_now("reset", idle_exp);
    rst = 1'b1;

    add_idle(4);
    for (int i = 0; i < 9; i++) add_frame(vecs[i]);
    add_idle(3);
    run_n(tl.size());

    // Abort during DATA cycle 5 of a fresh frame
    add_frame('{pe: 1'b1, s2: 1'b0, done_at: 7, spur: 1'b0, b2b: 1'b0});
    run_n(8);
    bus.data_valid = 1'b0;
    bus.ser_done   = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    tl.delete();
    err_sticky = 1'b0;
    idle_exp = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
    check_now("midreset", idle_exp);
    @(posedge clk);
    #1;
    rst = 1'b1;
    add_idle(2);
    add_frame('{pe: 1'b0, s2: 1'b1, done_at: 7, spur: 1'b0, b2b: 1'b0});
    add_frame('{pe: 1'b1, s2: 1'b0, done_at: 7, spur: 1'b0, b2b: 1'b1});
    add_idle(3);
    run_n(tl.size());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_fsm.md
Name: uart_tx_fsm

Overview:
- Control FSM that sequences the UART transmit datapath (serializer, parity calculator, output line mux) through start, data, parity and stop phases.
- Accepts one frame per valid/ready handshake from the upstream producer and drives the datapath's Load and mux_sel.
- Watches ser_done and flags a serializer that fails to finish.
- clk is the bit clock: one line bit per cycle.

Parameters:
- DATA_WIDTH, 8, data bits per frame; must match the datapath.
- WD_SLACK, 2, extra DATA-state cycles allowed beyond DATA_WIDTH before the watchdog fires.

Ports:
- clk  in  1  bit clock
- rst  in  1  asynchronous active-low reset
- data_valid  in  1  producer has a frame ready; datapath P_DATA is stable while high
- par_en  in  1  parity bit enable; sampled on accept
- stop2  in  1  two stop bits when 1; sampled on accept
- ser_done  in  1  serializer pulse, high in the cycle its last data bit is selected
- tx_ready  out  1  frame accepted this cycle when data_valid is also high
- ser_load  out  1  Load strobe to the datapath
- mux_sel  out  2  line select: 00 start, 01 idle/stop, 10 serial data, 11 parity
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse in the last stop cycle
- ser_err  out  1  sticky watchdog error

Behaviour:
- Reset (async, rst=0):
  - state=IDLE, mux_sel=01, busy=0, ser_load=0, frame_done=0, ser_err=0.
  - Counter and config registers are cleared.
  - Reset mid-frame aborts immediately; the line returns to idle one cycle after reset through the datapath register.
- States and Moore mux_sel:
  - IDLE=01, START=00, DATA=10, PARITY=11, STOP1=01, STOP2=01.
- Ready and accept:
  - tx_ready=1 in IDLE, and in the final stop cycle (STOP1 with stop2 latched 0, or STOP2).
  - accept = data_valid & tx_ready.
  - ser_load = accept, combinational, so the datapath loads on that same edge.
  - On accept, latch par_en and stop2, then go to START.
- Transitions:
  - IDLE: accept -> START, else stay.
  - START: -> DATA after 1 cycle; clear the watchdog counter.
  - DATA: ser_done -> PARITY if par_en latched, else STOP1. The counter increments each cycle; when it reaches DATA_WIDTH+WD_SLACK without ser_done, set ser_err and go to STOP1 (frame is truncated, never hangs).
  - PARITY: -> STOP1 after 1 cycle.
  - STOP1: if stop2 latched -> STOP2; otherwise accept -> START (back-to-back, no idle gap), else IDLE.
  - STOP2: accept -> START, else IDLE.
- ser_done outside DATA is ignored.
- busy = (state != IDLE), registered from state.
- frame_done = 1 in the final stop cycle, whether or not a new frame is accepted.
- ser_err is sticky until reset.
- Frame length in cycles: 1 start + DATA_WIDTH data + par_en + 1 + stop2.
- The line output lags mux_sel by one cycle because of the datapath output register.
- Example timing, DATA_WIDTH=8, par_en=1, stop2=0, accept at cycle 0:
  - START at cycle 1, DATA at cycles 2-9, ser_done at cycle 9.
  - PARITY at cycle 10, STOP1 at cycle 11 (frame_done=1).
  - Start bit appears on the line at cycle 2.
- Changes to data_valid, par_en or stop2 mid-frame have no effect.

Decomposition:
- Shared package:
  - mux_sel encodings: SEL_START=2'b00, SEL_IDLE=2'b01, SEL_DATA=2'b10, SEL_PAR=2'b11.
  - FSM state encoding localparams.
  - Watchdog counter width function, clog2(DATA_WIDTH+WD_SLACK+1).
- The same mux_sel constants are reused by the datapath.
- No sub-module: single FSM plus counter, roughly 150 lines.

Test Plan:
- Idle after reset: rst low for 3 cycles, then high with no data_valid -> mux_sel=01, busy=0, tx_ready=1, ser_load=0 indefinitely.
- Single frame: data_valid=1 at cycle 0, par_en=1, stop2=0, ser_done at cycle 9 -> ser_load=1 at 0; mux_sel 00@1, 10@2-9, 11@10, 01@11; frame_done@11; IDLE@12.
- Back-to-back: data_valid held high, par_en=0, stop2=1 -> STOP2 at cycle 11 with tx_ready=1 and ser_load=1; START at cycle 12; no IDLE cycle between frames.
- Watchdog: ser_done never asserted, WD_SLACK=2 -> DATA lasts 10 cycles, then STOP1; ser_err=1 and stays 1 through later good frames until reset.
- Reset mid-frame: rst low during DATA cycle 5 -> immediate IDLE, mux_sel=01, busy=0; the next accepted frame is complete and correct.
- Config isolation: toggle par_en and stop2 during DATA, plus a spurious ser_done in START -> frame follows the values latched at accept; the spurious ser_done has no effect.
